// File: rtl/sw_debounce.sv
// sw_debounce: switch input conditioning ahead of the core's io_sw_i.
// Each raw switch bit goes through a synchronizer chain and then its own
// debounce counter. The outputs are the stable levels, one-cycle change
// pulses, and an OR of those pulses.
// Optional feature macro: SW_STICKY_EN. When it is defined, a sticky
// per-bit event mask is built, and it is cleared by writing 1.

// Logic for one switch bit: synchronizer, debounce counter, stable level
// and change pulse.
module sw_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic change,
  output logic accept
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;
  logic                   differ;

  assign synced = sync[SYNC_STAGES-1];
  assign differ = synced ^ level;
  // The last count step and the level update happen on the same edge.
  assign accept = differ && (cnt == CNT_MAX);

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  // Debounce. The counter only runs while synced disagrees with the stable
  // level. Any agreement (a bounce back) restarts it. Because acceptance
  // clears the counter, it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      level  <= 1'b0;
      change <= 1'b0;
    end else begin
      change <= accept;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// Top level: one independent debouncer per switch bit.
module sw_debounce #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic [WIDTH-1:0] sw_change_o,
  output logic             sw_event_o,
  output logic [WIDTH-1:0] evt_mask_o,
  input  logic [WIDTH-1:0] evt_clr_i
);

  logic [WIDTH-1:0] accept;
  logic             event_q;

  genvar b;
  generate
    for (b = 0; b < WIDTH; b++) begin : g_bit
      sw_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk   (clk_i),
        .rst   (rst_i),
        .raw   (sw_raw_i[b]),
        .level (sw_o[b]),
        .change(sw_change_o[b]),
        .accept(accept[b])
      );
    end
  endgenerate

  // The event flag is registered from the same acceptance terms as the
  // change pulses, so it lines up with sw_change_o in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) event_q <= 1'b0;
    else       event_q <= |accept;
  end

  assign sw_event_o = event_q;

`ifdef SW_STICKY_EN
  logic [WIDTH-1:0] mask_q;

  // Sticky flags. A set from a change pulse wins over a clear on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mask_q <= '0;
    else       mask_q <= (mask_q & ~evt_clr_i) | sw_change_o;
  end

  assign evt_mask_o = mask_q;
`else
  logic unused_clr;

  assign unused_clr = |evt_clr_i;
  assign evt_mask_o = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with default parameters and a 20 ns clock.
// A table covers acceptance and latency. Hand sequences cover bounce,
// glitch, reset in the middle of a debounce, and the sticky mask.
module tb_sw_debounce;

  logic        clk;
  logic        rst;
  logic [31:0] raw;
  logic [31:0] sw;
  logic [31:0] chg;
  logic        evt;
  logic [31:0] mask;
  logic [31:0] clr;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int b2b    = 0;
  logic [31:0] prev_chg = '0;

  sw_debounce #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sw_raw_i   (raw),
    .sw_o       (sw),
    .sw_change_o(chg),
    .sw_event_o (evt),
    .evt_mask_o (mask),
    .evt_clr_i  (clr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] raw;
    int          steps;
    logic [31:0] sw;
    logic [31:0] chg;
    logic        evt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and sample on the falling edge. While sampling, count
  // change pulses and any change bit that stays high for two cycles.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pulses += $countones(chg);
      if ((prev_chg & chg) != 0) b2b++;
      prev_chg = chg;
    end
  endtask

  initial begin
    // Each entry: raw applied, cycles to wait, then expected sw/chg/evt.
    vecs[0] = '{32'h5,  17, 32'h0,  32'h0,  1'b0};
    vecs[1] = '{32'h5,   1, 32'h5,  32'h5,  1'b1};
    vecs[2] = '{32'h5,   1, 32'h5,  32'h0,  1'b0};
    vecs[3] = '{32'h5,   6, 32'h5,  32'h0,  1'b0};
    vecs[4] = '{32'hA0, 17, 32'h5,  32'h0,  1'b0};
    vecs[5] = '{32'hA0,  1, 32'hA0, 32'hA5, 1'b1};
    vecs[6] = '{32'hA0,  1, 32'hA0, 32'h0,  1'b0};
    vecs[7] = '{32'h0,  18, 32'h0,  32'hA0, 1'b1};
    vecs[8] = '{32'h0,   1, 32'h0,  32'h0,  1'b0};

    rst = 1'b1;
    raw = '0;
    clr = '0;

    // Test 1: reset holds every output at zero.
    tick(1);
    chk("rst_sw", sw, 32'h0);
    chk("rst_chg", chg, 32'h0);
    chk("rst_evt", {31'b0, evt}, 32'h0);
    chk("rst_mask", mask, 32'h0);
    tick(2);
    chk("rst_sw_late", sw, 32'h0);
    rst = 1'b0;

    // Test 2 and simultaneous multi-bit acceptance, driven from the table.
    for (int v = 0; v < 9; v++) begin
      raw = vecs[v].raw;
      tick(vecs[v].steps);
      chk($sformatf("vec%0d_sw", v), sw, vecs[v].sw);
      chk($sformatf("vec%0d_chg", v), chg, vecs[v].chg);
      chk($sformatf("vec%0d_evt", v), {31'b0, evt}, {31'b0, vecs[v].evt});
    end

    // Test 3: bit 0 starts stable high, bounces, then settles low.
    raw = 32'h1;
    tick(20);
    chk("bnc_pre_sw", sw, 32'h1);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      raw = 32'h0; tick(5);
      raw = 32'h1; tick(5);
    end
    chk("bnc_hold_sw", sw, 32'h1);
    raw = 32'h0;
    tick(17);
    chk("bnc_e17_sw", sw, 32'h1);
    chk("bnc_e17_pulses", pulses, 0);
    tick(1);
    chk("bnc_e18_sw", sw, 32'h0);
    chk("bnc_e18_chg", chg, 32'h1);
    tick(2);
    chk("bnc_pulses", pulses, 1);

    // Test 4: a 10-cycle glitch on bit 3 never gets through.
    pulses = 0;
    raw = 32'h8;
    tick(10);
    raw = 32'h0;
    tick(30);
    chk("glitch_sw", sw, 32'h0);
    chk("glitch_pulses", pulses, 0);

    // Test 5: reset arrives while bit 7 is partway through its debounce.
    raw = 32'h10;
    tick(20);
    chk("pre_rst_sw", sw, 32'h10);
    raw = 32'h90;
    tick(12);
    rst = 1'b1;
    #1;
    chk("mid_rst_sw", sw, 32'h0);
    chk("mid_rst_chg", chg, 32'h0);
    chk("mid_rst_evt", {31'b0, evt}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(17);
    chk("post_rst_e17_sw", sw, 32'h0);
    tick(1);
    chk("post_rst_e18_sw", sw, 32'h90);
    chk("post_rst_e18_chg", chg, 32'h90);
    tick(1);

`ifdef SW_STICKY_EN
    // Test 6: sticky mask set, clear, and set-wins-over-clear.
    clr = '1;
    tick(1);
    clr = '0;
    chk("stk_cleared", mask, 32'h0);
    raw = 32'h94;
    tick(18);
    chk("stk_set_chg", chg, 32'h4);
    tick(1);
    chk("stk_set", mask, 32'h4);
    raw = 32'h90;
    tick(18);
    chk("stk_pulse2", chg, 32'h4);
    clr = 32'h4;
    tick(1);
    clr = '0;
    chk("stk_set_wins", mask, 32'h4);
    tick(2);
    clr = 32'h4;
    tick(1);
    clr = '0;
    chk("stk_clr_alone", mask, 32'h0);
`else
    // Without the sticky feature, the mask stays zero whatever clr does.
    chk("nostk_mask_a", mask, 32'h0);
    clr = '1;
    raw = 32'h94;
    tick(19);
    chk("nostk_chg", chg, 32'h0);
    chk("nostk_sw", sw, 32'h94);
    chk("nostk_mask_b", mask, 32'h0);
    clr = '0;
`endif

    chk("no_back_to_back", b2b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
